bus_slave_mem: RTL and testbench

//  Responder end of the CPU word-access bus (cs_/as_/rw/addr/wr_data -> rd_data/rdy_).

---
 rtl/bus_slave_mem_pkg.sv | 30 +++
 rtl/bus_slave_wait_cnt.sv | 40 ++++
 rtl/bus_slave_mem.sv | 147 ++++++++++++++
 tb/tb_bus_slave_mem.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_slave_mem_pkg.sv
// Shared definitions for the word-access bus slaves: bus widths, strobe and
// direction encodings, slave FSM state encodings and the wait counter width.
package bus_slave_mem_pkg;

    localparam int WORD_ADDR_W    = 30;
    localparam int WORD_DATA_W    = 32;
    localparam int BUS_SLV_WAIT_W = 3;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef logic [WORD_ADDR_W-1:0] word_addr_t;
    typedef logic [WORD_DATA_W-1:0] word_data_t;

    typedef enum logic [2:0] {
        BUS_SLV_ST_IDLE = 3'd0,
        BUS_SLV_ST_WAIT = 3'd1,
        BUS_SLV_ST_MEM  = 3'd2,
        BUS_SLV_ST_RESP = 3'd3,
        BUS_SLV_ST_ERR  = 3'd4
    } bus_slv_st_e;

    // A word address is decodable only if every bit above the SRAM index is zero.
    function automatic logic addr_in_range(input word_addr_t addr, input int mem_addr_w);
        return (addr >> mem_addr_w) == '0;
    endfunction

endpackage

// File: rtl/bus_slave_wait_cnt.sv
// Load/decrement wait-state counter with a zero flag. Loading takes priority
// over decrementing, and the count holds at zero instead of wrapping.
module bus_slave_wait_cnt
    import bus_slave_mem_pkg::*;
#(
    parameter int CNT_W = BUS_SLV_WAIT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: load a fresh value or step down toward zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/bus_slave_mem.sv
// Bus responder in front of a single-port synchronous SRAM. Accepts one word
// access at a time, inserts WAIT_CYCLES wait states, performs a single SRAM
// cycle and answers with a one-cycle s_rdy_ pulse. Out-of-range addresses are
// answered immediately with err and never reach the SRAM.
module bus_slave_mem
    import bus_slave_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_ADDR_W  = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_cs_,
    input  logic                   s_as_,
    input  logic                   s_rw,
    input  logic [WORD_ADDR_W-1:0] s_addr,
    input  logic [WORD_DATA_W-1:0] s_wr_data,
    output logic [WORD_DATA_W-1:0] s_rd_data,
    output logic                   s_rdy_,
    output logic                   err,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    output logic [WORD_DATA_W-1:0] mem_wdata,
    input  logic [WORD_DATA_W-1:0] mem_rdata
);

    // The counter is loaded on WAIT entry so that it reads zero in the last WAIT cycle.
    localparam logic [BUS_SLV_WAIT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? BUS_SLV_WAIT_W'(WAIT_CYCLES - 1) : '0;

    bus_slv_st_e            state_d, state_q;
    logic [MEM_ADDR_W-1:0]  addr_d, addr_q;
    logic                   rw_d, rw_q;
    word_data_t             wdata_d, wdata_q;

    // Outputs are registered alongside the state they belong to.
    logic                   rdy_n_d, rdy_n_q;
    logic                   err_d, err_q;
    logic                   mem_en_d, mem_en_q;
    logic                   mem_we_d, mem_we_q;
    logic                   rd_resp_d, rd_resp_q;

    logic                   cnt_load;
    logic                   cnt_dec;
    logic                   cnt_zero;

    bus_slave_wait_cnt #(
        .CNT_W (BUS_SLV_WAIT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state, latch and registered-output decode for the access FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        rdy_n_d   = DISABLE_;
        err_d     = 1'b0;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        rd_resp_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        case (state_q)
            BUS_SLV_ST_IDLE: begin
                if ((s_cs_ == ENABLE_) && (s_as_ == ENABLE_)) begin
                    addr_d  = s_addr[MEM_ADDR_W-1:0];
                    rw_d    = s_rw;
                    wdata_d = s_wr_data;
                    if (!addr_in_range(s_addr, MEM_ADDR_W)) begin
                        state_d = BUS_SLV_ST_ERR;
                        rdy_n_d = ENABLE_;
                        err_d   = 1'b1;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d  = BUS_SLV_ST_WAIT;
                        cnt_load = 1'b1;
                    end else begin
                        state_d  = BUS_SLV_ST_MEM;
                        mem_en_d = 1'b1;
                        mem_we_d = (s_rw == WRITE);
                    end
                end
            end
            BUS_SLV_ST_WAIT: begin
                if (cnt_zero) begin
                    state_d  = BUS_SLV_ST_MEM;
                    mem_en_d = 1'b1;
                    mem_we_d = (rw_q == WRITE);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            BUS_SLV_ST_MEM: begin
                state_d   = BUS_SLV_ST_RESP;
                rdy_n_d   = ENABLE_;
                rd_resp_d = (rw_q == READ);
            end
            BUS_SLV_ST_RESP: state_d = BUS_SLV_ST_IDLE;
            BUS_SLV_ST_ERR:  state_d = BUS_SLV_ST_IDLE;
            default:         state_d = BUS_SLV_ST_IDLE;
        endcase
    end

    // State, request latches and registered outputs; reset drops mem_en immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BUS_SLV_ST_IDLE;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            rdy_n_q   <= DISABLE_;
            err_q     <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            rd_resp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            rdy_n_q   <= rdy_n_d;
            err_q     <= err_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            rd_resp_q <= rd_resp_d;
        end
    end

    // Read data is passed straight through during a read response and held at zero otherwise.
    assign s_rd_data = rd_resp_q ? mem_rdata : '0;
    assign s_rdy_    = rdy_n_q;
    assign err       = err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem: one instance with no wait states, one with
// a single wait state, each in front of its own behavioural SRAM.
module tb_bus_slave_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cs_n, as_n, rw, rdy_n, err, mem_en, mem_we;
    logic [29:0] addr      [2];
    logic [31:0] wdata     [2];
    logic [31:0] rd_data   [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [11:0] mem_addr  [2];
    logic [31:0] sram0 [4096];
    logic [31:0] sram1 [4096];

    int n_vec  = 0;
    int n_miss = 0;

    int          r_lat, r_en_cnt, r_en_cyc;
    logic        r_we, r_err, r_rdy_after;
    logic [11:0] r_maddr;
    logic [31:0] r_wd, r_rd;
    int          en_seen;

    always #5 clk = ~clk;

    bus_slave_mem #(.WAIT_CYCLES(0), .MEM_ADDR_W(12)) dut0 (
        .clk(clk), .reset(reset), .s_cs_(cs_n[0]), .s_as_(as_n[0]), .s_rw(rw[0]),
        .s_addr(addr[0]), .s_wr_data(wdata[0]), .s_rd_data(rd_data[0]), .s_rdy_(rdy_n[0]),
        .err(err[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    bus_slave_mem #(.WAIT_CYCLES(1), .MEM_ADDR_W(12)) dut1 (
        .clk(clk), .reset(reset), .s_cs_(cs_n[1]), .s_as_(as_n[1]), .s_rw(rw[1]),
        .s_addr(addr[1]), .s_wr_data(wdata[1]), .s_rd_data(rd_data[1]), .s_rdy_(rdy_n[1]),
        .err(err[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    // Behavioural single-port SRAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en[0]) begin
            if (mem_we[0]) sram0[mem_addr[0]] <= mem_wdata[0];
            else           mem_rdata[0] <= sram0[mem_addr[0]];
        end
        if (mem_en[1]) begin
            if (mem_we[1]) sram1[mem_addr[1]] <= mem_wdata[1];
            else           mem_rdata[1] <= sram1[mem_addr[1]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Follow an already-accepted access cycle by cycle until s_rdy_ falls,
    // then look one cycle further to confirm the ready pulse has ended.
    task automatic finish_access(input int i);
        r_lat = -1; r_en_cnt = 0; r_en_cyc = -1; r_we = 1'b0; r_maddr = '0;
        r_wd = '0; r_rd = '0; r_err = 1'b0; r_rdy_after = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (mem_en[i]) begin
                r_en_cnt++;
                r_en_cyc = n;
                r_we     = mem_we[i];
                r_maddr  = mem_addr[i];
                r_wd     = mem_wdata[i];
            end
            if (!rdy_n[i]) begin
                r_lat = n;
                r_rd  = rd_data[i];
                r_err = err[i];
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        r_rdy_after = rdy_n[i];
    endtask

    task automatic do_access(input int i, input logic rd, input logic [29:0] a, input logic [31:0] d);
        cs_n[i] = 1'b0; as_n[i] = 1'b0; rw[i] = rd; addr[i] = a; wdata[i] = d;
        @(posedge clk); #1;
        cs_n[i] = 1'b1; as_n[i] = 1'b1;
        finish_access(i);
    endtask

    task automatic chk_write(input string tag, input int lat, input logic [11:0] a, input logic [31:0] d);
        check({tag, ".lat"},   32'(r_lat),       32'(lat));
        check({tag, ".en_n"},  32'(r_en_cnt),    32'd1);
        check({tag, ".en_at"}, 32'(r_en_cyc),    32'(lat - 1));
        check({tag, ".we"},    32'(r_we),        32'd1);
        check({tag, ".maddr"}, 32'(r_maddr),     32'(a));
        check({tag, ".wdata"}, r_wd,             d);
        check({tag, ".rdata"}, r_rd,             32'd0);
        check({tag, ".err"},   32'(r_err),       32'd0);
        check({tag, ".rdy1"},  32'(r_rdy_after), 32'd1);
    endtask

    task automatic chk_read(input string tag, input int lat, input logic [11:0] a, input logic [31:0] d);
        check({tag, ".lat"},   32'(r_lat),       32'(lat));
        check({tag, ".en_n"},  32'(r_en_cnt),    32'd1);
        check({tag, ".we"},    32'(r_we),        32'd0);
        check({tag, ".maddr"}, 32'(r_maddr),     32'(a));
        check({tag, ".rdata"}, r_rd,             d);
        check({tag, ".err"},   32'(r_err),       32'd0);
        check({tag, ".rdy1"},  32'(r_rdy_after), 32'd1);
    endtask

    task automatic chk_err(input string tag);
        check({tag, ".lat"},   32'(r_lat),       32'd1);
        check({tag, ".err"},   32'(r_err),       32'd1);
        check({tag, ".en_n"},  32'(r_en_cnt),    32'd0);
        check({tag, ".rdata"}, r_rd,             32'd0);
        check({tag, ".rdy1"},  32'(r_rdy_after), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cs_n = 2'b11; as_n = 2'b11; rw = 2'b00;
        addr[0] = '0; wdata[0] = '0;
        // dut1 sees a write request already pending while reset is held
        cs_n[1] = 1'b0; as_n[1] = 1'b0; rw[1] = 1'b0; addr[1] = 30'h005; wdata[1] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        check("rst.rdy1",  32'(rdy_n[1]),  32'd1);
        check("rst.en1",   32'(mem_en[1]), 32'd0);
        check("rst.we1",   32'(mem_we[1]), 32'd0);
        check("rst.err1",  32'(err[1]),    32'd0);
        check("rst.rd1",   rd_data[1],     32'd0);
        check("rst.rdy0",  32'(rdy_n[0]),  32'd1);
        check("rst.en0",   32'(mem_en[0]), 32'd0);

        // Released mid-cycle: the pending write is taken on the very next edge
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        cs_n[1] = 1'b1; as_n[1] = 1'b1;
        finish_access(1);
        chk_write("wr5", 3, 12'h005, 32'hDEADBEEF);
        check("wr5.sram", sram1[5], 32'hDEADBEEF);

        do_access(1, 1'b1, 30'h005, 32'h0);
        chk_read("rd5", 3, 12'h005, 32'hDEADBEEF);

        // No wait states: fill words 0..3
        for (int k = 0; k < 4; k++) begin
            do_access(0, 1'b0, 30'(k), 32'hA5A5_0000 + 32'(k));
            chk_write($sformatf("wr0_%0d", k), 2, 12'(k), 32'hA5A5_0000 + 32'(k));
        end
        do_access(0, 1'b1, 30'h002, 32'h0);
        chk_read("rd0_2", 2, 12'h002, 32'hA5A5_0002);

        // Back-to-back reads with s_as_ held low: one access every 3 cycles
        cs_n[0] = 1'b0; as_n[0] = 1'b0; rw[0] = 1'b1; addr[0] = 30'h000;
        @(posedge clk); #1;
        for (int t = 1; t <= 12; t++) begin
            check($sformatf("b2b.en_t%0d", t), 32'(mem_en[0]), 32'(t % 3 == 1));
            check($sformatf("b2b.rdy_t%0d", t), 32'(rdy_n[0]), 32'(t % 3 != 2));
            if (t % 3 == 1) begin
                check($sformatf("b2b.maddr_t%0d", t), 32'(mem_addr[0]), 32'((t - 1) / 3));
            end
            if (t % 3 == 2) begin
                check($sformatf("b2b.rd_t%0d", t), rd_data[0], 32'hA5A5_0000 + 32'((t - 2) / 3));
                if (t == 11) begin
                    cs_n[0] = 1'b1; as_n[0] = 1'b1;
                end else begin
                    addr[0] = addr[0] + 30'd1;
                end
            end
            @(posedge clk); #1;
        end

        // Out-of-range accesses answer at once with err and leave the SRAM alone
        do_access(0, 1'b0, 30'h0001000, 32'h0BAD_0BAD);
        chk_err("oor_wr");
        check("oor_wr.sram0", sram0[0], 32'hA5A5_0000);
        do_access(0, 1'b1, 30'h2000_0000, 32'h0);
        chk_err("oor_rd");

        // Reset while waiting: the write never reaches the SRAM
        cs_n[1] = 1'b0; as_n[1] = 1'b0; rw[1] = 1'b0; addr[1] = 30'h005; wdata[1] = 32'h1234_5678;
        @(posedge clk); #1;
        cs_n[1] = 1'b1; as_n[1] = 1'b1;
        check("rstw.en_wait", 32'(mem_en[1]), 32'd0);
        reset   = 1'b1;
        en_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_en[1]) en_seen++;
        end
        check("rstw.en_seen", 32'(en_seen), 32'd0);
        check("rstw.rdy", 32'(rdy_n[1]), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        do_access(1, 1'b1, 30'h005, 32'h0);
        chk_read("rstw_rd", 3, 12'h005, 32'hDEADBEEF);

        // Reset during the SRAM cycle: mem_en drops before the edge, so no write lands
        cs_n[1] = 1'b0; as_n[1] = 1'b0; rw[1] = 1'b0; addr[1] = 30'h005; wdata[1] = 32'h5555_5555;
        @(posedge clk); #1;
        cs_n[1] = 1'b1; as_n[1] = 1'b1;
        @(posedge clk); #1;
        check("rstm.en_mem", 32'(mem_en[1]), 32'd1);
        reset = 1'b1;
        #1;
        check("rstm.en_async", 32'(mem_en[1]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        do_access(1, 1'b1, 30'h005, 32'h0);
        chk_read("rstm_rd", 3, 12'h005, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
